// File: rtl/qspi_arbiter.sv
// ============================================================================
// qspi_arbiter
// ----------------------------------------------------------------------------
// Shares a single QSPI controller command port between an instruction-fetch
// requester and a data requester. It accepts one transaction at a time,
// decodes the 25-bit address into a target device and a 23-bit device
// address, issues a one-cycle start pulse to the controller, waits for the
// controller's done pulse, and returns read data plus a one-cycle done pulse
// to the requester that owns the transaction.
//
// Address map (bits [24:23]):
//   00 / 01 -> flash  (ctrl_sel = 0)
//   10      -> RAM A  (ctrl_sel = 1)
//   11      -> RAM B  (ctrl_sel = 2)
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   i_req, i_addr         : instruction read request and byte address
//   i_done, i_err         : instruction completion pulse, error (never set)
//   d_req, d_addr         : data request and byte address
//   d_write, d_len        : data direction, transfer length (bytes-1)
//   d_wdata               : data write payload
//   d_done, d_err         : data completion pulse, error pulse
//   rdata                 : read data, valid with i_done / d_done
//   ctrl_start            : one-cycle command strobe to the controller
//   ctrl_addr, ctrl_sel   : device address and device select
//   ctrl_write, ctrl_len  : command direction and length
//   ctrl_wdata            : command write payload
//   ctrl_busy             : controller busy, blocks new captures
//   ctrl_done, ctrl_rdata : controller completion pulse and read data
// ============================================================================
module qspi_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [24:0] i_addr,
    output logic        i_done,
    output logic        i_err,

    input  logic        d_req,
    input  logic [24:0] d_addr,
    input  logic        d_write,
    input  logic [1:0]  d_len,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic        d_err,

    output logic [31:0] rdata,

    output logic        ctrl_start,
    output logic [22:0] ctrl_addr,
    output logic [1:0]  ctrl_sel,
    output logic        ctrl_write,
    output logic [1:0]  ctrl_len,
    output logic [31:0] ctrl_wdata,

    input  logic        ctrl_busy,
    input  logic        ctrl_done,
    input  logic [31:0] ctrl_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Device select from the two top address bits.
    function automatic logic [1:0] decode_sel(input logic [24:0] addr);
        logic [1:0] sel;
        if (!addr[24]) begin
            sel = 2'd0;
        end else if (!addr[23]) begin
            sel = 2'd1;
        end else begin
            sel = 2'd2;
        end
        return sel;
    endfunction

    state_t      state_q,      state_d;
    logic        last_data_q,  last_data_d;   // last grant went to data
    logic        owner_data_q, owner_data_d;  // current transaction is data
    logic        err_q,        err_d;         // current transaction is rejected

    logic        ctrl_start_q, ctrl_start_d;
    logic [22:0] ctrl_addr_q,  ctrl_addr_d;
    logic [1:0]  ctrl_sel_q,   ctrl_sel_d;
    logic        ctrl_write_q, ctrl_write_d;
    logic [1:0]  ctrl_len_q,   ctrl_len_d;
    logic [31:0] ctrl_wdata_q, ctrl_wdata_d;

    logic [31:0] rdata_q,      rdata_d;
    logic        i_done_q,     i_done_d;
    logic        d_done_q,     d_done_d;
    logic        d_err_q,      d_err_d;

    logic        grant_data;
    logic        flash_write;

    // ------------------------------------------------------------------
    // Next-state and output computation
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        owner_data_d = owner_data_q;
        err_d        = err_q;

        ctrl_start_d = 1'b0;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_sel_d   = ctrl_sel_q;
        ctrl_write_d = ctrl_write_q;
        ctrl_len_d   = ctrl_len_q;
        ctrl_wdata_d = ctrl_wdata_q;

        rdata_d      = rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        d_err_d      = 1'b0;

        // Data normally wins, but after a data grant a waiting instruction
        // fetch takes the next slot so neither side can be starved.
        grant_data   = d_req && !(last_data_q && i_req);
        flash_write  = d_write && !d_addr[24];

        case (state_q)
            ST_IDLE: begin
                if (!ctrl_busy && (i_req || d_req)) begin
                    state_d      = ST_ISSUE;
                    owner_data_d = grant_data;
                    last_data_d  = grant_data;
                    if (grant_data) begin
                        err_d = flash_write;
                        // A rejected flash write never reaches the
                        // controller, so the command registers keep their
                        // previous contents.
                        if (!flash_write) begin
                            ctrl_start_d = 1'b1;
                            ctrl_addr_d  = d_addr[22:0];
                            ctrl_sel_d   = decode_sel(d_addr);
                            ctrl_write_d = d_write;
                            ctrl_len_d   = d_len;
                            ctrl_wdata_d = d_wdata;
                        end
                    end else begin
                        // Instruction fetches are always full-word reads.
                        err_d        = 1'b0;
                        ctrl_start_d = 1'b1;
                        ctrl_addr_d  = i_addr[22:0];
                        ctrl_sel_d   = decode_sel(i_addr);
                        ctrl_write_d = 1'b0;
                        ctrl_len_d   = 2'd3;
                        ctrl_wdata_d = 32'd0;
                    end
                end
            end

            ST_ISSUE: begin
                if (err_q) begin
                    // Nothing was issued, so there is nothing to wait for:
                    // report the error directly.
                    state_d  = ST_RESP;
                    d_done_d = 1'b1;
                    d_err_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (ctrl_done) begin
                    state_d = ST_RESP;
                    rdata_d = ctrl_rdata;
                    if (owner_data_q) begin
                        d_done_d = 1'b1;
                    end else begin
                        i_done_d = 1'b1;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_data_q  <= 1'b0;
            owner_data_q <= 1'b0;
            err_q        <= 1'b0;
            ctrl_start_q <= 1'b0;
            ctrl_addr_q  <= 23'd0;
            ctrl_sel_q   <= 2'd0;
            ctrl_write_q <= 1'b0;
            ctrl_len_q   <= 2'd0;
            ctrl_wdata_q <= 32'd0;
            rdata_q      <= 32'd0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            owner_data_q <= owner_data_d;
            err_q        <= err_d;
            ctrl_start_q <= ctrl_start_d;
            ctrl_addr_q  <= ctrl_addr_d;
            ctrl_sel_q   <= ctrl_sel_d;
            ctrl_write_q <= ctrl_write_d;
            ctrl_len_q   <= ctrl_len_d;
            ctrl_wdata_q <= ctrl_wdata_d;
            rdata_q      <= rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            d_err_q      <= d_err_d;
        end
    end

    assign ctrl_start = ctrl_start_q;
    assign ctrl_addr  = ctrl_addr_q;
    assign ctrl_sel   = ctrl_sel_q;
    assign ctrl_write = ctrl_write_q;
    assign ctrl_len   = ctrl_len_q;
    assign ctrl_wdata = ctrl_wdata_q;
    assign rdata      = rdata_q;
    assign i_done     = i_done_q;
    assign d_done     = d_done_q;
    assign d_err      = d_err_q;
    assign i_err      = 1'b0;

endmodule

// File: tb/tb_qspi_arbiter.sv
// ============================================================================
// tb_qspi_arbiter
// ----------------------------------------------------------------------------
// Directed bench for qspi_arbiter. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, so every registered
// output reflects the edge just taken.
// ============================================================================
module tb_qspi_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [24:0] i_addr;
    logic        i_done;
    logic        i_err;
    logic        d_req;
    logic [24:0] d_addr;
    logic        d_write;
    logic [1:0]  d_len;
    logic [31:0] d_wdata;
    logic        d_done;
    logic        d_err;
    logic [31:0] rdata;
    logic        ctrl_start;
    logic [22:0] ctrl_addr;
    logic [1:0]  ctrl_sel;
    logic        ctrl_write;
    logic [1:0]  ctrl_len;
    logic [31:0] ctrl_wdata;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic [31:0] ctrl_rdata;

    int n_pass  = 0;
    int n_total = 0;

    qspi_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_done     (i_done),
        .i_err      (i_err),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_write    (d_write),
        .d_len      (d_len),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_err      (d_err),
        .rdata      (rdata),
        .ctrl_start (ctrl_start),
        .ctrl_addr  (ctrl_addr),
        .ctrl_sel   (ctrl_sel),
        .ctrl_write (ctrl_write),
        .ctrl_len   (ctrl_len),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_busy  (ctrl_busy),
        .ctrl_done  (ctrl_done),
        .ctrl_rdata (ctrl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-22s observed=%h expected=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All outputs zero (used after reset).
    task automatic chk_all_zero(input string tag);
        chk({tag, ".start"}, {31'd0, ctrl_start}, 32'd0);
        chk({tag, ".addr"},  {9'd0, ctrl_addr},   32'd0);
        chk({tag, ".sel"},   {30'd0, ctrl_sel},   32'd0);
        chk({tag, ".write"}, {31'd0, ctrl_write}, 32'd0);
        chk({tag, ".len"},   {30'd0, ctrl_len},   32'd0);
        chk({tag, ".wdata"}, ctrl_wdata,          32'd0);
        chk({tag, ".rdata"}, rdata,               32'd0);
        chk({tag, ".dones"}, {28'd0, i_done, d_done, i_err, d_err}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_addr     = '0;
        d_write    = 1'b0;
        d_len      = '0;
        d_wdata    = '0;
        ctrl_busy  = 1'b0;
        ctrl_done  = 1'b0;
        ctrl_rdata = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // ---------------- instruction read from flash ----------------
        i_req  = 1'b1;
        i_addr = 25'h0000100;
        tick();                                   // captured -> ISSUE
        chk("i.start",  {31'd0, ctrl_start}, 32'd1);
        chk("i.sel",    {30'd0, ctrl_sel},   32'd0);
        chk("i.addr",   {9'd0, ctrl_addr},   32'h100);
        chk("i.len",    {30'd0, ctrl_len},   32'd3);
        chk("i.write",  {31'd0, ctrl_write}, 32'd0);
        tick();                                   // WAIT (first cycle)
        chk("i.start_1cyc", {31'd0, ctrl_start}, 32'd0);
        ctrl_done  = 1'b1;                        // done in the entry cycle
        ctrl_rdata = 32'hDEADBEEF;
        tick();                                   // RESP
        chk("i.i_done", {31'd0, i_done}, 32'd1);
        chk("i.d_done", {31'd0, d_done}, 32'd0);
        chk("i.rdata",  rdata, 32'hDEADBEEF);
        chk("i.addr_hold", {9'd0, ctrl_addr}, 32'h100);
        ctrl_done = 1'b0;
        i_req     = 1'b0;
        tick();                                   // IDLE
        chk("i.done_1cyc", {31'd0, i_done}, 32'd0);

        // ---------------- stale ctrl_done in IDLE is ignored ----------------
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        chk("idle_done.dones", {30'd0, i_done, d_done}, 32'd0);
        chk("idle_done.start", {31'd0, ctrl_start}, 32'd0);

        // ---------------- both requesters, last owner instruction ----------------
        i_req   = 1'b1;
        i_addr  = 25'h0000200;
        d_req   = 1'b1;
        d_addr  = 25'h1000020;                    // RAM A
        d_write = 1'b0;
        d_len   = 2'd3;
        tick();                                   // data wins
        chk("arb1.start", {31'd0, ctrl_start}, 32'd1);
        chk("arb1.sel",   {30'd0, ctrl_sel},   32'd1);
        chk("arb1.addr",  {9'd0, ctrl_addr},   32'h20);
        tick();                                   // WAIT
        tick();                                   // WAIT
        chk("arb1.wait_start", {31'd0, ctrl_start}, 32'd0);
        chk("arb1.wait_dones", {30'd0, i_done, d_done}, 32'd0);
        ctrl_done  = 1'b1;
        ctrl_rdata = 32'hCAFEF00D;
        tick();                                   // RESP
        chk("arb1.dones", {30'd0, i_done, d_done}, 32'd1);
        chk("arb1.rdata", rdata, 32'hCAFEF00D);
        ctrl_done = 1'b0;                         // d_req stays asserted
        tick();                                   // IDLE
        chk("arb1.idle_start", {31'd0, ctrl_start}, 32'd0);
        tick();                                   // instruction wins now
        chk("arb2.start", {31'd0, ctrl_start}, 32'd1);
        chk("arb2.sel",   {30'd0, ctrl_sel},   32'd0);
        chk("arb2.addr",  {9'd0, ctrl_addr},   32'h200);
        chk("arb2.len",   {30'd0, ctrl_len},   32'd3);
        d_req = 1'b0;
        tick();                                   // WAIT
        ctrl_done  = 1'b1;
        ctrl_rdata = 32'h11223344;
        tick();                                   // RESP
        chk("arb2.dones", {30'd0, i_done, d_done}, 32'd2);
        chk("arb2.rdata", rdata, 32'h11223344);
        ctrl_done = 1'b0;
        i_req     = 1'b0;
        tick();                                   // IDLE

        // ---------------- data write to RAM B ----------------
        d_req   = 1'b1;
        d_write = 1'b1;
        d_addr  = 25'h1800010;
        d_len   = 2'd1;
        d_wdata = 32'h00001234;
        tick();
        chk("wr.start", {31'd0, ctrl_start}, 32'd1);
        chk("wr.sel",   {30'd0, ctrl_sel},   32'd2);
        chk("wr.addr",  {9'd0, ctrl_addr},   32'h10);
        chk("wr.write", {31'd0, ctrl_write}, 32'd1);
        chk("wr.len",   {30'd0, ctrl_len},   32'd1);
        chk("wr.wdata", ctrl_wdata,          32'h00001234);
        tick();                                   // WAIT
        ctrl_done  = 1'b1;
        ctrl_rdata = 32'hAAAA5555;
        tick();                                   // RESP
        chk("wr.d_done", {31'd0, d_done}, 32'd1);
        chk("wr.d_err",  {31'd0, d_err},  32'd0);
        ctrl_done = 1'b0;
        d_req     = 1'b0;
        tick();                                   // IDLE

        // ---------------- data write to flash: rejected ----------------
        d_req   = 1'b1;
        d_write = 1'b1;
        d_addr  = 25'h0000040;
        tick();                                   // ISSUE, nothing issued
        chk("fe.no_start", {31'd0, ctrl_start}, 32'd0);
        chk("fe.no_done",  {30'd0, d_done, d_err}, 32'd0);
        tick();                                   // RESP
        chk("fe.done_err", {30'd0, d_done, d_err}, 32'd3);
        chk("fe.i_done",   {31'd0, i_done}, 32'd0);
        chk("fe.rdata",    rdata, 32'hAAAA5555);
        chk("fe.start",    {31'd0, ctrl_start}, 32'd0);
        d_req   = 1'b0;
        d_write = 1'b0;
        tick();                                   // IDLE
        chk("fe.pulse_1cyc", {30'd0, d_done, d_err}, 32'd0);

        // ---------------- controller busy holds off capture ----------------
        ctrl_busy = 1'b1;
        i_req     = 1'b1;
        i_addr    = 25'h0000300;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("busy.no_start", {31'd0, ctrl_start}, 32'd0);
        end
        ctrl_busy = 1'b0;
        tick();
        chk("busy.start", {31'd0, ctrl_start}, 32'd1);
        chk("busy.addr",  {9'd0, ctrl_addr},   32'h300);

        // ---------------- reset during WAIT ----------------
        tick();                                   // WAIT
        tick();                                   // WAIT
        rst   = 1'b1;
        i_req = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        rst        = 1'b0;
        ctrl_done  = 1'b1;                        // stale completion
        ctrl_rdata = 32'h55555555;
        tick();
        ctrl_done = 1'b0;
        chk_all_zero("rst_stale");
        tick();
        chk("rst.no_done", {30'd0, i_done, d_done}, 32'd0);

        // New request is served promptly, proving the arbiter sits in IDLE.
        i_req  = 1'b1;
        i_addr = 25'h0000400;
        tick();
        chk("post.start", {31'd0, ctrl_start}, 32'd1);
        chk("post.addr",  {9'd0, ctrl_addr},   32'h400);
        tick();
        ctrl_done  = 1'b1;
        ctrl_rdata = 32'h0BADF00D;
        tick();
        chk("post.dones", {30'd0, i_done, d_done}, 32'd2);
        chk("post.rdata", rdata, 32'h0BADF00D);
        ctrl_done = 1'b0;
        i_req     = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
